// File: rtl/clk_prescaler_4040_if.sv
// Control/status bundle between the sequencing controller and the divide-by-R prescaler.
interface clk_prescaler_4040_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div;
  logic             q;
  logic             tc;
  logic             pend;

  modport master (
    output en,
    output load,
    output div,
    input  q,
    input  tc,
    input  pend
  );

  modport slave (
    input  en,
    input  load,
    input  div,
    output q,
    output tc,
    output pend
  );
endinterface

// File: rtl/clk_prescaler_4040.sv
// Programmable divide-by-R prescaler driving the 744040 ripple counter clock (q falls once per R clocks).
// Build option PRESCALER_DUTY50_EN: q is high for the first ceil(R/2) counts instead of a one-cycle low pulse.
module clk_prescaler_4040 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  clk_prescaler_4040_if.slave  bus
);
  // state   | meaning
  // ST_STOP | active ratio < 2: cnt=0, q parked high, a load applies at once
  // ST_RUN  | cnt walks 0..n_act-1; reloads are held in n_pend until the wrap
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] n_pend_q, n_pend_d;
  logic             pend_q, pend_d;
  logic             q_q, q_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_d;
`ifdef PRESCALER_DUTY50_EN
  logic [WIDTH-1:0] half_d;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_STOP;
      cnt_q    <= '0;
      n_act_q  <= '0;
      n_pend_q <= '0;
      pend_q   <= 1'b0;
      q_q      <= 1'b1;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_act_q  <= n_act_d;
      n_pend_q <= n_pend_d;
      pend_q   <= pend_d;
      q_q      <= q_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_act_d  = n_act_q;
    n_pend_d = n_pend_q;
    pend_d   = pend_q;
    q_d      = q_q;
    tc_d     = 1'b0;
    last_q   = n_act_q - ONE;

    case (state_q)
      ST_STOP: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (bus.load) begin
          n_act_d = bus.div;
        end
      end
      ST_RUN: begin
        if (bus.en && (cnt_q == last_q)) begin
          // Wrap edge: a load arriving right now wins over anything pending.
          cnt_d  = '0;
          pend_d = 1'b0;
          if (bus.load) begin
            n_act_d = bus.div;
          end else if (pend_q) begin
            n_act_d = n_pend_q;
          end
        end else begin
          if (bus.en) begin
            cnt_d = cnt_q + ONE;
          end
          if (bus.load) begin
            n_pend_d = bus.div;
            pend_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase

    state_d = (n_act_d >= TWO) ? ST_RUN : ST_STOP;
    last_d  = n_act_d - ONE;
`ifdef PRESCALER_DUTY50_EN
    half_d  = (n_act_d >> 1) + {{(WIDTH-1){1'b0}}, n_act_d[0]};
`endif

    // While frozen (en=0 and already running) q and cnt simply hold and tc stays low.
    if (state_d == ST_STOP) begin
      cnt_d = '0;
      q_d   = 1'b1;
      tc_d  = 1'b0;
    end else if (bus.en || (state_q == ST_STOP)) begin
`ifdef PRESCALER_DUTY50_EN
      q_d  = (cnt_d < half_d);
`else
      q_d  = (cnt_d != last_d);
`endif
      tc_d = bus.en && (cnt_d == last_d);
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.pend = pend_q;

endmodule

// File: tb/tb_clk_prescaler_4040.sv
// Directed self-checking bench for clk_prescaler_4040: per-cycle q/tc/pend scoreboard plus q falling-edge counts.
module tb_clk_prescaler_4040;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  clk_prescaler_4040_if #(.WIDTH(WIDTH)) bus ();

  clk_prescaler_4040 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic  q;
    logic  tc;
    logic  pend;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   falls = 0;

  // Stand-in for the downstream 744040: it advances on every q falling edge.
  always @(negedge bus.q) falls++;

  function automatic logic exp_q(input int c, input int r);
`ifdef PRESCALER_DUTY50_EN
    return (c < (r + 1) / 2);
`else
    return (c != r - 1);
`endif
  endfunction

  task automatic check_bit(input string tag, input string what, input logic got, input logic want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s %s: got %b expected %b", tag, what, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue what q/tc/pend must read after that edge, then compare.
  task automatic step(input bit c_clr, input bit e, input bit l, input int d,
                      input logic eq, input logic etc, input logic ep, input string tag);
    exp_t x;
    clr      = c_clr;
    bus.en   = e;
    bus.load = l;
    bus.div  = d[WIDTH-1:0];
    x.q = eq; x.tc = etc; x.pend = ep; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    bus.load = 1'b0;
    if (sb.size() == 0) begin
      check_int({tag, "_sb_empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      check_bit(x.tag, "q",    bus.q,    x.q);
      check_bit(x.tag, "tc",   bus.tc,   x.tc);
      check_bit(x.tag, "pend", bus.pend, x.pend);
    end
  endtask

  // Free-running at ratio r with en=1; c is the count position after the last edge.
  task automatic run(input int r, inout int c, input int n, input logic ep, input string tag);
    for (int i = 0; i < n; i++) begin
      c = (c + 1) % r;
      step(1'b0, 1'b1, 1'b0, 0, exp_q(c, r), (c == r - 1), ep, tag);
    end
  endtask

  initial begin
    int c;
    int f0;
    clr      = 1'b1;
    bus.en   = 1'b1;
    bus.load = 1'b0;
    bus.div  = '0;
    c        = 0;

    // Reset and idle: stopped, q parked high
    repeat (2) step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "reset");
    repeat (10) step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "idle");
    check_int("idle_falls", falls, 0);

    // Divide by 4 from stopped: first low 3 clocks after the load edge
    f0 = falls;
    step(1'b0, 1'b1, 1'b1, 4, exp_q(0, 4), 1'b0, 1'b0, "load4");
    c = 0;
    run(4, c, 40, 1'b0, "r4");
    check_int("r4_falls", falls - f0, 10);

    // Reload 6 while running 4: pend for 3 cycles, period completes on the 4 boundary
    step(1'b0, 1'b1, 1'b1, 6, exp_q(1, 4), 1'b0, 1'b1, "ld6");
    c = 1;
    run(4, c, 2, 1'b1, "r4_pend6");
    step(1'b0, 1'b1, 1'b0, 0, exp_q(0, 6), 1'b0, 1'b0, "wrap6");
    c = 0;
    f0 = falls;
    run(6, c, 12, 1'b0, "r6");
    check_int("r6_falls", falls - f0, 2);

    // Back to 4, then freeze at cnt=2 for 5 cycles with a load captured while frozen
    step(1'b0, 1'b1, 1'b1, 4, exp_q(1, 6), 1'b0, 1'b1, "ld4");
    c = 1;
    run(6, c, 4, 1'b1, "r6_pend4");
    step(1'b0, 1'b1, 1'b0, 0, exp_q(0, 4), 1'b0, 1'b0, "wrap4");
    c = 0;
    run(4, c, 2, 1'b0, "r4_pre_freeze");
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, exp_q(2, 4), 1'b0, 1'b0, "freeze");
    step(1'b0, 1'b0, 1'b1, 4, exp_q(2, 4), 1'b0, 1'b1, "freeze_ld");
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, exp_q(2, 4), 1'b0, 1'b1, "freeze_pend");
    run(4, c, 1, 1'b1, "thaw");
    step(1'b0, 1'b1, 1'b0, 0, exp_q(0, 4), 1'b0, 1'b0, "thaw_wrap");
    c = 0;
    run(4, c, 4, 1'b0, "r4_post");

    // Reload 1 stops at the wrap; load 3 restarts immediately
    step(1'b0, 1'b1, 1'b1, 1, exp_q(1, 4), 1'b0, 1'b1, "ld1");
    c = 1;
    run(4, c, 2, 1'b1, "r4_pend1");
    step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "stop");
    f0 = falls;
    repeat (8) step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "stopped");
    check_int("stopped_falls", falls - f0, 0);
    step(1'b0, 1'b1, 1'b1, 3, exp_q(0, 3), 1'b0, 1'b0, "ld3");
    c = 0;
    run(3, c, 6, 1'b0, "r3");

    // clr with a concurrent load: load discarded, stays stopped
    step(1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, "clr_ld");
    f0 = falls;
    repeat (8) step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "clr_stopped");
    check_int("clr_falls", falls - f0, 0);

    // Divide by 5 for 50 clocks
    step(1'b0, 1'b1, 1'b1, 5, exp_q(0, 5), 1'b0, 1'b0, "ld5");
    c = 0;
    f0 = falls;
    run(5, c, 50, 1'b0, "r5");
    check_int("r5_falls", falls - f0, 10);

    // Second load while pending overwrites the first
    step(1'b0, 1'b1, 1'b1, 7, exp_q(1, 5), 1'b0, 1'b1, "ld7");
    c = 1;
    step(1'b0, 1'b1, 1'b1, 3, exp_q(2, 5), 1'b0, 1'b1, "ld3_over");
    c = 2;
    run(5, c, 2, 1'b1, "r5_pend3");
    step(1'b0, 1'b1, 1'b0, 0, exp_q(0, 3), 1'b0, 1'b0, "wrap3");
    c = 0;
    run(3, c, 2, 1'b0, "r3_to_tc");

    // Load in the terminal-count cycle: applied at that wrap, pend never rises
    step(1'b0, 1'b1, 1'b1, 2, exp_q(0, 2), 1'b0, 1'b0, "ld_tc");
    c = 0;
    run(2, c, 6, 1'b0, "r2");

    // Largest legal ratio
    step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "clr_max");
    step(1'b0, 1'b1, 1'b1, 255, exp_q(0, 255), 1'b0, 1'b0, "ld255");
    c = 0;
    f0 = falls;
    run(255, c, 510, 1'b0, "r255");
    check_int("r255_falls", falls - f0, 2);

    check_int("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_prescaler_4040.md
Name: clk_prescaler_4040

Overview:
Synchronous programmable divide-by-R prescaler. Sits directly upstream of the 12-bit ripple counter (counter_744040) and drives that counter's falling-edge clock input. Produces one falling edge on q per R input clocks. Also provides a terminal-count strobe and a pending-reload flag so the controller can change R without glitching the downstream count.

Parameters:
WIDTH, 8, width of the divide-ratio input and the internal counter; R ranges 2..2^WIDTH-1

Ports:
clk   input   1      system clock; all state updates on rising edge
clr   input   1      reset, synchronous, active-high
en    input   1      count enable; low freezes the prescaler
div   input   WIDTH  requested divide ratio R; values 0 and 1 mean "stopped"
load  input   1      single-cycle strobe; captures div
q     output  1      divided clock to downstream counter; idles high
tc    output  1      one-cycle terminal-count pulse, once per period
pend  output  1      high while a captured ratio waits to be applied

Behaviour:
- Internal state: cnt[WIDTH-1:0], active ratio n_act, pending ratio n_pend, pend flag. All outputs are registered.
- Reset (clr=1 at a rising edge):
  - cnt=0, n_act=0 (stopped), pend=0, q=1, tc=0.
  - clr overrides load and en in the same cycle; a concurrent load is discarded.
- Stopped (n_act<2):
  - cnt=0, q=1, tc=0; no edges on q.
  - A load applies immediately at that edge: n_act=div, cnt=0, q=1, pend stays 0.
- Running (n_act>=2, en=1):
  - cnt steps 0,1,...,n_act-1 and wraps to 0.
  - q=0 and tc=1 exactly in the cycle where cnt==n_act-1; otherwise q=1, tc=0.
  - Consequence: the q falling edge occurs n_act-1 clocks after the load edge, then every n_act clocks.
- Reload while running:
  - load sets n_pend=div and pend=1.
  - The pending value is applied at the edge where cnt wraps from n_act-1 to 0: n_act=n_pend, pend=0. The current period always completes.
  - load during the terminal-count cycle: the new value takes effect at that same wrap, and pend never asserts.
  - A second load while pend=1 overwrites n_pend.
  - A pending value <2 stops the prescaler at the wrap: q holds 1, tc=0.
- en=0: cnt, q, tc and n_act hold. tc is forced to 0 while en=0, so it cannot double-count. load still captures into n_pend (or applies immediately if stopped). Pending application waits for the wrap.
- Arithmetic:
  - Compare cnt against n_act-1 at WIDTH bits; no overflow is possible because n_act>=2.
  - cnt never exceeds n_act-1.
  - div=2^WIDTH-1 is legal.

Optional Feature:
Macro PRESCALER_DUTY50_EN.
- Defined: q runs at near-50% duty.
  - q=1 for cnt < ceil(n_act/2), q=0 otherwise.
  - The q falling edge occurs at cnt==ceil(n_act/2).
  - tc is unchanged (pulse at cnt==n_act-1).
  - Stopped behaviour is unchanged.
- Not defined: single-cycle low pulse as above.

Test Plan:
1. Reset: clr=1 for 2 cycles, then idle 10 cycles with load=0 -> q=1, tc=0, pend=0 throughout; downstream counter stays 0.
2. Load div=4 -> q low one cycle every 4 clocks, first low 3 clocks after the load edge; 40 clocks give 10 falling edges (downstream q=10), and tc coincides with q low.
3. Running R=4, load div=6 at cnt=1 -> pend=1 for 3 cycles; current period ends on the 4-clock boundary; the next periods are 6 clocks each; pend=0 after the wrap.
4. Running R=4, en=0 for 5 cycles at cnt=2 -> cnt holds at 2, q holds 1, tc=0; that period stretches to 9 clocks and the next is 4.
5. Running R=4, load div=1 -> current period completes, then q=1 and tc=0 permanently; a later load div=3 restarts with first low 2 clocks after load. In the same test, clr together with load div=5 -> stopped, pend=0, no q edges.
6. PRESCALER_DUTY50_EN defined, load div=5 -> q high 3 / low 2 repeating; tc at cnt=4; 50 clocks give 10 falling edges.
